z2_bus_frontend: RTL and testbench

//  Zorro II / 68000 bus front end feeding the card's slave blocks (SDRAM, IDE, autoconfig, control reg, flash).

---
 rtl/z2_bus_frontend_if.sv | 28 ++
 rtl/z2_bus_frontend.sv | 109 ++++++++++
 tb/tb_z2_bus_frontend.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/z2_bus_frontend_if.sv
// Zorro II bus-side signal bundle between the card's bus pins/slaves and the cycle front end.
// The master side drives the raw strobes and slave decode/ready terms; the slave side is the front end.
interface z2_bus_frontend_if;
  logic       AS_n;
  logic       UDS_n;
  logic       LDS_n;
  logic       RW;
  logic       device_hit;
  logic       ack_in;
  logic       as_n_s;
  logic       uds_n_s;
  logic       lds_n_s;
  logic       rw_s;
  logic [1:0] z2_state;
  logic       dtack;
  logic       timeout;
  logic       busy;

  modport master (
    output AS_n, UDS_n, LDS_n, RW, device_hit, ack_in,
    input  as_n_s, uds_n_s, lds_n_s, rw_s, z2_state, dtack, timeout, busy
  );

  modport slave (
    input  AS_n, UDS_n, LDS_n, RW, device_hit, ack_in,
    output as_n_s, uds_n_s, lds_n_s, rw_s, z2_state, dtack, timeout, busy
  );
endinterface

// File: rtl/z2_bus_frontend.sv
// Zorro II / 68000 bus front end: strobe synchronisers, Z2 cycle FSM, registered dtack and
// a watchdog that ends a START/DATA cycle no slave ever acknowledges.
module z2_bus_frontend #(
  parameter int AS_STAGES      = 3,
  parameter int STB_STAGES     = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic              MEMCLK,
  input  logic              RESET,
  z2_bus_frontend_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] TO_MAX  = '1;

  logic [AS_STAGES-1:0]  r_as;
  logic [STB_STAGES-1:0] r_uds;
  logic [STB_STAGES-1:0] r_lds;
  logic [STB_STAGES-1:0] r_rw;
  logic [1:0]            r_state;
  logic                  r_dtack;
  logic                  r_timeout;
  logic [TO_WIDTH-1:0]   r_cnt;

  logic w_as_start;
  logic w_as_end;
  logic w_strobe;
  logic w_to_hit;
  logic w_active;

  // Plain shift chains; the whole chain is forced idle-high on reset.
  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      r_as  <= '1;
      r_uds <= '1;
      r_lds <= '1;
      r_rw  <= '1;
    end else begin
      r_as  <= {r_as[AS_STAGES-2:0],   bus.AS_n};
      r_uds <= {r_uds[STB_STAGES-2:0], bus.UDS_n};
      r_lds <= {r_lds[STB_STAGES-2:0], bus.LDS_n};
      r_rw  <= {r_rw[STB_STAGES-2:0],  bus.RW};
    end
  end

  // Cycle start waits for the deepest tap; end/abort reacts one tap earlier.
  assign w_as_start = r_as[AS_STAGES-1];
  assign w_as_end   = r_as[AS_STAGES-2];
  assign w_strobe   = ~r_uds[STB_STAGES-1] | ~r_lds[STB_STAGES-1];
  assign w_to_hit   = (r_cnt == TO_LAST);
  assign w_active   = (r_state == S_START) || (r_state == S_DATA);

  always_ff @(posedge MEMCLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_dtack   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      if (w_active) r_cnt <= (r_cnt == TO_MAX) ? r_cnt : r_cnt + 1'b1;
      else          r_cnt <= '0;

      case (r_state)
        S_IDLE: begin
          r_dtack <= 1'b0;
          if (!w_as_start && bus.device_hit) r_state <= S_START;
        end
        S_START, S_DATA: begin
          // Master abort beats the watchdog, which beats a normal advance.
          if (w_as_end) begin
            r_state <= S_IDLE;
          end else if (w_to_hit) begin
            r_state   <= S_END;
            r_timeout <= 1'b1;
          end else if (r_state == S_START) begin
            if (w_strobe) r_state <= S_DATA;
          end else if (bus.ack_in) begin
            r_dtack <= 1'b1;
            r_state <= S_END;
          end
        end
        S_END: begin
          if (w_as_end) begin
            r_dtack <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.as_n_s   = w_as_end;
  assign bus.uds_n_s  = r_uds[STB_STAGES-1];
  assign bus.lds_n_s  = r_lds[STB_STAGES-1];
  assign bus.rw_s     = r_rw[STB_STAGES-1];
  assign bus.z2_state = r_state;
  assign bus.dtack    = r_dtack;
  assign bus.timeout  = r_timeout;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_z2_bus_frontend.sv
// Bench for z2_bus_frontend: each bus cycle's outcome is derived from edge arithmetic on the
// chosen pin timing and queued; a monitor pops and compares on every observed output change.
module tb_z2_bus_frontend;
  localparam int AS_ST  = 3;
  localparam int STB_ST = 2;
  localparam int TO_CYC = 8;
  localparam int TO_W   = 8;
  localparam int NEVER  = 1000;

  typedef struct packed {
    int         cyc;
    logic [1:0] st;
    logic       dt;
    logic       to;
    logic       busy;
  } ev_t;

  logic MEMCLK = 1'b0;
  logic RESET;
  z2_bus_frontend_if bus();

  z2_bus_frontend #(
    .AS_STAGES(AS_ST), .STB_STAGES(STB_ST), .TIMEOUT_CYCLES(TO_CYC), .TO_WIDTH(TO_W)
  ) dut (
    .MEMCLK(MEMCLK), .RESET(RESET), .bus(bus)
  );

  always #5 MEMCLK = ~MEMCLK;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  logic h_as[8], h_uds[8], h_lds[8], h_rw[8], h_rst[8];

  // Pin history per edge, for the "pin delayed by N edges" expectation of the sync outputs.
  always @(posedge MEMCLK) begin
    cyc = cyc + 1;
    h_as[cyc%8]  = bus.AS_n;
    h_uds[cyc%8] = bus.UDS_n;
    h_lds[cyc%8] = bus.LDS_n;
    h_rw[cyc%8]  = bus.RW;
    h_rst[cyc%8] = RESET;
  end

  function automatic logic dly(input int which, input int e, input int i);
    for (int j = e - i; j <= e; j++) if (h_rst[j%8] === 1'b1) return 1'b1;
    case (which)
      0:       return h_as[(e-i)%8];
      1:       return h_uds[(e-i)%8];
      2:       return h_lds[(e-i)%8];
      default: return h_rw[(e-i)%8];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor
  initial begin
    ev_t prev, obs, e;
    wait (mon_en);
    prev = '0;
    forever begin
      @(negedge MEMCLK);
      check("as_n_s",  {31'd0, bus.as_n_s},  {31'd0, dly(0, cyc, AS_ST-2)});
      check("uds_n_s", {31'd0, bus.uds_n_s}, {31'd0, dly(1, cyc, STB_ST-1)});
      check("lds_n_s", {31'd0, bus.lds_n_s}, {31'd0, dly(2, cyc, STB_ST-1)});
      check("rw_s",    {31'd0, bus.rw_s},    {31'd0, dly(3, cyc, STB_ST-1)});
      obs = '{cyc: cyc, st: bus.z2_state, dt: bus.dtack, to: bus.timeout, busy: bus.busy};
      if ({obs.st, obs.dt, obs.to, obs.busy} !== {prev.st, prev.dt, prev.to, prev.busy}) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_change: got st=%0d dtack=%b timeout=%b busy=%b at cycle %0d, expected no change",
                   obs.st, obs.dt, obs.to, obs.busy, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_outputs", {27'd0, obs.st, obs.dt, obs.to, obs.busy},
                                 {27'd0, e.st, e.dt, e.to, e.busy});
        end
        prev = obs;
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missed_event: got no change by cycle %0d, expected st=%0d dtack=%b timeout=%b at cycle %0d",
                 cyc, e.st, e.dt, e.to, e.cyc);
      end
    end
  end

  task automatic drive_idle();
    bus.AS_n = 1'b1; bus.UDS_n = 1'b1; bus.LDS_n = 1'b1; bus.RW = 1'b1;
    bus.device_hit = 1'b0; bus.ack_in = 1'b0; RESET = 1'b0;
  endtask

  // One bus cycle, edges numbered from 1 after the call. Strobes fall before edge s, ack_in rises
  // before edge a (0 = never), everything releases before edge r, RESET pulses at edge rst (0 = none).
  task automatic run_txn(input bit hit, input int s, input int a, input int r, input int rst,
                         input bit rw, input bit use_u, input bit use_l, input bit drop_hit);
    int B, len, A, W, Dd, ackE, win_e, win_k;
    logic [1:0] st[0:63];
    logic       dt[0:63], to[0:63];
    logic [3:0] pv;
    B   = cyc;
    len = r + 5;
    A   = r + AS_ST - 1;           // release seen at the end tap
    W   = (AS_ST + 1) + TO_CYC;    // watchdog TIMEOUT_CYCLES edges after START
    Dd  = (s + STB_ST < AS_ST + 2) ? AS_ST + 2 : s + STB_ST;
    if (s >= r || (!use_u && !use_l)) Dd = NEVER;
    if (a == 0) ackE = NEVER;
    else begin
      ackE = (a > Dd + 1) ? a : Dd + 1;
      if (ackE >= r) ackE = NEVER;
    end
    win_e = A; win_k = 0;
    if (W < win_e)    begin win_e = W;    win_k = 1; end
    if (ackE < win_e) begin win_e = ackE; win_k = 2; end
    for (int k = 0; k <= len; k++) begin
      st[k] = 2'd0; dt[k] = 1'b0; to[k] = 1'b0;
      if (hit && k >= AS_ST + 1) begin
        if (k < win_e) st[k] = (k >= Dd) ? 2'd2 : 2'd1;
        else if (win_k != 0 && k < A) begin
          st[k] = 2'd3;
          dt[k] = (win_k == 2);
          to[k] = (win_k == 1 && k == win_e);
        end
      end
      if (rst != 0 && k >= rst) begin st[k] = 2'd0; dt[k] = 1'b0; to[k] = 1'b0; end
    end
    pv = {st[0], dt[0], to[0]};
    for (int k = 1; k <= len; k++) begin
      if ({st[k], dt[k], to[k]} != pv)
        exp_q.push_back('{cyc: B + k, st: st[k], dt: dt[k], to: to[k], busy: (st[k] != 2'd0)});
      pv = {st[k], dt[k], to[k]};
    end
    for (int k = 1; k <= len; k++) begin
      bus.AS_n       = !(k < r);
      bus.UDS_n      = !(use_u && k >= s && k < r);
      bus.LDS_n      = !(use_l && k >= s && k < r);
      bus.RW         = (k < r) ? rw : 1'b1;
      bus.device_hit = hit && (k < r) && !(drop_hit && k >= AS_ST + 2);
      bus.ack_in     = (a != 0) && (k >= a) && (k < r);
      RESET          = (rst != 0) && (k == rst);
      @(negedge MEMCLK);
    end
    drive_idle();
  endtask

  initial begin
    int kind, s, a, r, rst;
    bit u, l;
    // Reset with every pin asserted: taps must still read idle-high.
    RESET = 1'b1;
    bus.AS_n = 1'b0; bus.UDS_n = 1'b0; bus.LDS_n = 1'b0; bus.RW = 1'b0;
    bus.device_hit = 1'b1; bus.ack_in = 1'b1;
    repeat (4) @(negedge MEMCLK);
    check("rst_state",   {30'd0, bus.z2_state}, 32'd0);
    check("rst_dtack",   {31'd0, bus.dtack},    32'd0);
    check("rst_timeout", {31'd0, bus.timeout},  32'd0);
    check("rst_busy",    {31'd0, bus.busy},     32'd0);
    check("rst_taps",    {28'd0, bus.as_n_s, bus.uds_n_s, bus.lds_n_s, bus.rw_s}, 32'hF);
    drive_idle();
    mon_en = 1'b1;
    @(negedge MEMCLK);

    run_txn(1, 1, 1, 8, 0, 1, 1, 0, 0);     // read to hit: START e4, DATA e5, dtack e6
    run_txn(0, 1, 1, 21, 0, 1, 1, 1, 0);    // miss held 20 cycles
    run_txn(1, 1, 0, 16, 0, 0, 1, 1, 0);    // watchdog from DATA
    run_txn(1, 1, 0, 7, 0, 1, 0, 1, 1);     // abort in DATA, device_hit dropped
    run_txn(1, 1, 0, 7, 7, 1, 1, 1, 0);     // reset mid-DATA
    run_txn(1, 2, 3, 12, 0, 0, 1, 1, 0);    // recovery
    run_txn(1, 1, 0, 10, 0, 1, 1, 0, 0);    // abort and watchdog same edge
    run_txn(1, 1, 12, 16, 0, 1, 0, 1, 0);   // watchdog and ack same edge
    run_txn(1, 1, 3, 15, 0, 1, 0, 0, 0);    // no data strobe: watchdog from START

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      s = $urandom_range(1, 5); a = $urandom_range(1, 11);
      u = $urandom_range(0, 1); l = !u || ($urandom_range(0, 1) == 1);
      rst = 0;
      case (kind)
        0: r = $urandom_range(14, 18);
        1: r = $urandom_range(10, 22);
        2: begin a = 0; s = $urandom_range(1, 12); r = $urandom_range(10, 18); end
        3: begin a = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(9, 12); r = $urandom_range(4, 10); end
        default: begin rst = $urandom_range(5, 10); r = rst; end
      endcase
      run_txn(kind != 1, s, a, r, rst, 1'($urandom_range(0, 1)), u, l, 1'($urandom_range(0, 1)));
    end

    repeat (6) @(negedge MEMCLK);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
